// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: opcodes, controller states, ALU ops
// and the per-state strobe pattern used by the control unit.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
    I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    FETCH, IR_LOAD, DECODE, LOAD_ADDR, LOAD_WB,
    STORE, ALU_EXEC, MOVE_EXEC, BRANCH_TAKE, HALTED
  } ctrl_state_type;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef struct packed {
    logic branch;
    logic pc_enable;
    logic ir_enable;
    logic addr_sel;
    logic c_sel;
    logic write_reg_enable;
    logic flags_reg_enable;
    logic ram_write_enable;
    logic halt;
  } ctrl_strobes_type;

  // Moore strobe pattern for a state; operation is handled separately.
  function automatic ctrl_strobes_type strobes_for(ctrl_state_type s);
    ctrl_strobes_type c;
    c = '0;
    case (s)
      IR_LOAD:     begin c.ir_enable = 1'b1; c.pc_enable = 1'b1; end
      LOAD_ADDR:   c.addr_sel = 1'b1;
      LOAD_WB:     begin c.addr_sel = 1'b1; c.write_reg_enable = 1'b1; end
      STORE:       begin c.addr_sel = 1'b1; c.ram_write_enable = 1'b1; end
      ALU_EXEC:    begin c.c_sel = 1'b1; c.write_reg_enable = 1'b1; c.flags_reg_enable = 1'b1; end
      MOVE_EXEC:   begin c.c_sel = 1'b1; c.write_reg_enable = 1'b1; end
      BRANCH_TAKE: begin c.branch = 1'b1; c.pc_enable = 1'b1; end
      HALTED:      c.halt = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: take is high when the decoded opcode is
// a branch whose flag condition holds.
module branch_cond_eval
  import k_and_s_pkg::*;
(
  input  decoded_instruction_type decoded_instruction,
  input  logic                    reg_zero,
  input  logic                    reg_neg,
  input  logic                    reg_ov,
  output logic                    take
);

  always_comb begin
    take = 1'b0;
    case (decoded_instruction)
      I_BRANCH: take = 1'b1;
      I_BZERO:  take = reg_zero;
      I_BNZERO: take = !reg_zero;
      I_BNEG:   take = reg_neg;
      I_BNNEG:  take = !reg_neg;
      I_BOV:    take = reg_ov;
      I_BNOV:   take = !reg_ov;
      default:  take = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore controller for the K&S processor; all outputs registered
// with the state. KS_SINGLE_STEP_EN gates FETCH on the step input.
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    reg_zero,
  input  logic                    reg_neg,
  input  logic                    reg_ov,
  input  logic                    reg_sov,
  input  logic                    step,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  ctrl_state_type   state, next_state;
  ctrl_strobes_type strobes;
  logic [1:0]       next_op;
  logic             take;
  logic             unused_inputs;

`ifdef KS_SINGLE_STEP_EN
  assign unused_inputs = reg_sov;
`else
  assign unused_inputs = reg_sov ^ step;
`endif

  branch_cond_eval u_branch_cond_eval (
    .decoded_instruction (decoded_instruction),
    .reg_zero            (reg_zero),
    .reg_neg             (reg_neg),
    .reg_ov              (reg_ov),
    .take                (take)
  );

  always_comb begin
    next_state = state;
    next_op    = OP_OR;
    case (state)
`ifdef KS_SINGLE_STEP_EN
      FETCH:       next_state = step ? IR_LOAD : FETCH;
`else
      FETCH:       next_state = IR_LOAD;
`endif
      IR_LOAD:     next_state = DECODE;
      DECODE: begin
        case (decoded_instruction)
          I_LOAD:  next_state = LOAD_ADDR;
          I_STORE: next_state = STORE;
          I_MOVE:  next_state = MOVE_EXEC;
          I_ADD:   begin next_state = ALU_EXEC; next_op = OP_ADD; end
          I_SUB:   begin next_state = ALU_EXEC; next_op = OP_SUB; end
          I_AND:   begin next_state = ALU_EXEC; next_op = OP_AND; end
          I_OR:    begin next_state = ALU_EXEC; next_op = OP_OR;  end
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                   next_state = take ? BRANCH_TAKE : FETCH;
          I_HALT:  next_state = HALTED;
          default: next_state = FETCH;
        endcase
      end
      LOAD_ADDR:   next_state = LOAD_WB;
      HALTED:      next_state = HALTED;
      default:     next_state = FETCH;
    endcase
  end

  // Outputs are computed from next_state so they change together with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      strobes   <= '0;
      operation <= OP_OR;
    end else begin
      state     <= next_state;
      strobes   <= strobes_for(next_state);
      operation <= (next_state == ALU_EXEC) ? next_op : OP_OR;
    end
  end

  assign branch           = strobes.branch;
  assign pc_enable        = strobes.pc_enable;
  assign ir_enable        = strobes.ir_enable;
  assign addr_sel         = strobes.addr_sel;
  assign c_sel            = strobes.c_sel;
  assign write_reg_enable = strobes.write_reg_enable;
  assign flags_reg_enable = strobes.flags_reg_enable;
  assign ram_write_enable = strobes.ram_write_enable;
  assign halt             = strobes.halt;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe sequences built
// from the instruction timing rules, compared every cycle on the falling edge.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  decoded_instruction_type decoded_instruction = I_NOP;
  logic reg_zero = 1'b0, reg_neg = 1'b0, reg_ov = 1'b0, reg_sov = 1'b0;
`ifdef KS_SINGLE_STEP_EN
  logic step = 1'b1;
`else
  logic step = 1'b0;
`endif
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
    .reg_zero(reg_zero), .reg_neg(reg_neg), .reg_ov(reg_ov), .reg_sov(reg_sov),
    .step(step), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .ram_write_enable(ram_write_enable), .halt(halt)
  );

  always #5 clk = ~clk;

  // Packed view: {halt,branch,pc,ir,addr_sel,c_sel,op[1:0],wr_reg,flags,ram_wr}
  function automatic logic [10:0] actual();
    return {halt, branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
            write_reg_enable, flags_reg_enable, ram_write_enable};
  endfunction

  function automatic logic [10:0] mk(logic h, logic b, logic pc, logic ir, logic as,
                                     logic cs, logic [1:0] op, logic wr, logic fl, logic rw);
    return {h, b, pc, ir, as, cs, op, wr, fl, rw};
  endfunction

  function automatic logic cond_true(decoded_instruction_type op, logic z, logic n, logic v);
    logic f;
    f = (op == I_BZERO || op == I_BNZERO) ? z :
        (op == I_BNEG  || op == I_BNNEG)  ? n : v;
    if (op == I_BRANCH) return 1'b1;
    if (op == I_BNZERO || op == I_BNNEG || op == I_BNOV) return !f;
    return f;
  endfunction

  // Expected per-cycle outputs from FETCH up to (not including) the next FETCH.
  function automatic void build_expected(decoded_instruction_type op, logic z, logic n, logic v);
    exp_q.delete();
    exp_q.push_back(11'd0);
    exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0));
    exp_q.push_back(11'd0);
    case (op)
      I_ADD:   exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'b01, 1, 1, 0));
      I_SUB:   exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'b10, 1, 1, 0));
      I_AND:   exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'b11, 1, 1, 0));
      I_OR:    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0));
      I_MOVE:  exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0));
      I_STORE: exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 1));
      I_LOAD: begin
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 2'b00, 1, 0, 0));
      end
      I_HALT:  exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
        if (cond_true(op, z, n, v)) exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0));
      default: ;
    endcase
  endfunction

  // Runs one instruction from a FETCH falling edge; lim>0 stops after lim
  // samples without advancing past the last one.
  task automatic run_instr(input decoded_instruction_type op, input logic z, input logic n,
                           input logic v, input string name, input int lim);
    int count;
    decoded_instruction = op;
    reg_zero = z; reg_neg = n; reg_ov = v; reg_sov = 1'($urandom_range(0, 1));
    build_expected(op, z, n, v);
    count = (lim > 0) ? lim : exp_q.size();
    for (int i = 0; i < count; i++) begin
      vectors++;
      if (actual() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s %s cycle %0d: got %b expected %b", name, op.name(), i, actual(), exp_q[i]);
      end
      if (lim == 0 || i < count - 1) @(negedge clk);
    end
  endtask

  task automatic expect_zero(input string name);
    vectors++;
    if (actual() !== 11'd0) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, actual(), 11'd0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    expect_zero("reset_hold");
    rst_n = 1'b1;
    expect_zero("reset_release");
  endtask

  task automatic test_alu();
    run_instr(I_ADD, 0, 0, 0, "add", 0);
    for (int i = 0; i < 12; i++)
      run_instr(decoded_instruction_type'($urandom_range(4, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "alu", 0);
    run_instr(I_MOVE, 1, 1, 1, "move", 0);
    run_instr(I_NOP, 0, 1, 0, "nop", 0);
  endtask

  task automatic test_load_store();
    run_instr(I_LOAD, 0, 0, 0, "load", 0);
    run_instr(I_STORE, 0, 0, 0, "store", 0);
    run_instr(I_LOAD, 1, 1, 1, "load_b2b", 0);
  endtask

  task automatic test_branches();
    for (int b = 8; b <= 14; b++)
      for (int f = 0; f < 8; f++)
        run_instr(decoded_instruction_type'(b), f[0], f[1], f[2], "branch", 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      run_instr(decoded_instruction_type'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random", 0);
  endtask

  task automatic test_reset_mid();
    run_instr(I_LOAD, 0, 0, 0, "load_to_addr", 4);
    rst_n = 1'b0;
    #1 expect_zero("reset_in_load_addr");
    @(negedge clk);
    expect_zero("reset_no_wr_pulse");
    rst_n = 1'b1;
    run_instr(I_LOAD, 0, 0, 0, "load_to_wb", 5);
    rst_n = 1'b0;
    #1 expect_zero("reset_in_load_wb");
    @(negedge clk);
    expect_zero("reset_in_load_wb_hold");
    rst_n = 1'b1;
    run_instr(I_ADD, 0, 0, 0, "after_reset", 0);
  endtask

  task automatic test_halt();
    run_instr(I_HALT, 0, 0, 0, "halt", 0);
    for (int i = 0; i < 100; i++) begin
      decoded_instruction = decoded_instruction_type'($urandom_range(0, 15));
      reg_zero = 1'($urandom_range(0, 1));
      vectors++;
      if (actual() !== mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0)) begin
        miscompares++;
        $display("FAIL halt_hold cycle %0d: got %b expected %b", i, actual(),
                 mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1 expect_zero("halt_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(I_STORE, 0, 0, 0, "post_halt", 0);
  endtask

`ifdef KS_SINGLE_STEP_EN
  task automatic test_single_step();
    step = 1'b0;
    decoded_instruction = I_ADD;
    build_expected(I_ADD, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      expect_zero("step_hold");
      @(negedge clk);
    end
    step = 1'b1;
    expect_zero("step_fetch");
    @(negedge clk);
    step = 1'b0;
    for (int i = 1; i < exp_q.size(); i++) begin
      vectors++;
      if (actual() !== exp_q[i]) begin
        miscompares++;
        $display("FAIL step_instr cycle %0d: got %b expected %b", i, actual(), exp_q[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      expect_zero("step_hold_after");
      @(negedge clk);
    end
    step = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branches();
    test_back_to_back();
    test_reset_mid();
    test_halt();
`ifdef KS_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
